// File: rtl/bus_serializer_if.sv
// Bus between a parent block and the serializer: parallel word handshake in,
// serial bit stream plus frame status out.
interface bus_serializer_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] i;
  logic             ready;
  logic             valid;
  logic             return_bit;
  logic             done;

  modport master (
    output load,
    output i,
    input  ready,
    input  valid,
    input  return_bit,
    input  done
  );

  modport slave (
    input  load,
    input  i,
    output ready,
    output valid,
    output return_bit,
    output done
  );
endinterface

// File: rtl/bus_serializer.sv
// Parallel-to-serial frame sender: WIDTH data bits LSB first, optional even
// parity bit, then a one-cycle done pulse before returning to idle.
module bus_serializer #(
  parameter int WIDTH     = 5,
  parameter int PARITY_EN = 1
) (
  input logic             _clock,
  input logic             _reset,
  bus_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             parity_q, parity_d;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    parity_d = parity_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shreg_d  = bus.i;
          parity_d = ^bus.i;
          count_d  = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q >> 1;
        if (count_q == LAST) begin
          count_d = '0;
          state_d = (PARITY_EN != 0) ? S_PARITY : S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_PARITY: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are pure state decodes so they follow reset in the same cycle.
  assign bus.ready      = (state_q == S_IDLE);
  assign bus.valid      = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign bus.done       = (state_q == S_DONE);
  assign bus.return_bit = (state_q == S_SHIFT)  ? shreg_q[0] :
                          (state_q == S_PARITY) ? parity_q   : 1'b0;
endmodule

// File: tb/tb_bus_serializer.sv
// Scoreboard bench: stimulus queues the expected serial stream, per-DUT
// monitors pop and compare on every valid bit and every done pulse.
module tb_bus_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_serializer_if #(.WIDTH(5)) bus_a ();
  bus_serializer_if #(.WIDTH(5)) bus_b ();

  bus_serializer #(.WIDTH(5), .PARITY_EN(1)) u_dut_a (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus_a)
  );

  bus_serializer #(.WIDTH(5), .PARITY_EN(0)) u_dut_b (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_b[$];
  int cyc = 0;
  int exp_a, exp_b;
  logic prev_valid_b = 1'b0;
  int last_start_b = -1;
  int periods_b = 0;

  // Queue entries: 0/1 = expected serial bit, 2 = expected done pulse.
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s value=%0d (t=%0t)", name, act, $time);
    end
  endtask

  function automatic void push_a(input int seq[6]);
    for (int k = 0; k < 6; k++) q_a.push_back(seq[k]);
    q_a.push_back(2);
  endfunction

  function automatic void push_b(input int seq[5]);
    for (int k = 0; k < 5; k++) q_b.push_back(seq[k]);
    q_b.push_back(2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.valid) begin
      chk("a_done_during_valid", int'(bus_a.done), 0);
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_bit actual=%0d required=none", bus_a.return_bit);
      end else begin
        exp_a = q_a.pop_front();
        chk("a_bit", int'(bus_a.return_bit), exp_a);
      end
    end else begin
      chk("a_return_when_invalid", int'(bus_a.return_bit), 0);
      if (bus_a.done) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_done actual=1 required=0");
        end else begin
          exp_a = q_a.pop_front();
          chk("a_done_position", exp_a, 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.valid) begin
      if (!prev_valid_b) begin
        if (last_start_b >= 0) begin
          chk("b_frame_period", cyc - last_start_b, 7);
          periods_b++;
        end
        last_start_b = cyc;
      end
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_bit actual=%0d required=none", bus_b.return_bit);
      end else begin
        exp_b = q_b.pop_front();
        chk("b_bit", int'(bus_b.return_bit), exp_b);
      end
    end else if (bus_b.done) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done actual=1 required=0");
      end else begin
        exp_b = q_b.pop_front();
        chk("b_done_position", exp_b, 2);
      end
    end
    prev_valid_b = bus_b.valid;
  end

  task automatic wait_ready_a();
    int n = 0;
    while (!bus_a.ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_wait_ready", int'(bus_a.ready), 1);
  endtask

  // Returns positioned #1 after the accepting edge (cycle 1 of the frame).
  task automatic send_a(input logic [4:0] word);
    wait_ready_a();
    bus_a.i    = word;
    bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    bus_a.i    = ~word;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  int'(bus_a.ready), 1);
    chk({tag, "_valid"},  int'(bus_a.valid), 0);
    chk({tag, "_return"}, int'(bus_a.return_bit), 0);
    chk({tag, "_done"},   int'(bus_a.done), 0);
  endtask

  initial begin
    int n;
    bus_a.load = 1'b0; bus_a.i = '0;
    bus_b.load = 1'b0; bus_b.i = '0;

    // Reset held low while inputs toggle.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus_a.load = k[0];
      bus_a.i    = 5'($urandom);
      @(negedge clk); #1;
      check_reset_outputs("rst_hold");
    end
    rst_n = 1'b1;
    bus_a.load = 1'b0;
    @(posedge clk); #1;

    // Frame 10110: bits 0,1,1,0,1 then parity 1; done on cycle 7, ready on 8.
    push_a('{0, 1, 1, 0, 1, 1});
    send_a(5'b10110);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t2_valid_c%0d", k), int'(bus_a.valid), (k <= 6) ? 1 : 0);
      chk($sformatf("t2_done_c%0d", k),  int'(bus_a.done),  (k == 7) ? 1 : 0);
      chk($sformatf("t2_ready_c%0d", k), int'(bus_a.ready), (k == 8) ? 1 : 0);
      @(posedge clk); #1;
    end

    push_a('{0, 0, 0, 0, 0, 0});
    send_a(5'b00000);
    push_a('{1, 1, 1, 1, 1, 1});
    send_a(5'b11111);
    wait_ready_a();

    // Load pulsed mid-frame must be ignored.
    push_a('{0, 0, 1, 1, 1, 1});
    send_a(5'b11100);
    bus_a.i    = 5'b01010;
    bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    wait_ready_a();
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t4_still_idle", int'(bus_a.ready), 1);
    chk("t4_queue_drained", q_a.size(), 0);

    // Reset dropped in cycle 3 aborts the frame with no done pulse.
    push_a('{0, 1, 1, 0, 1, 1});
    send_a(5'b10110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_mid_frame_valid", int'(bus_a.valid), 1);
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check_reset_outputs("t5_abort");
    repeat (2) begin
      @(negedge clk); #1;
      check_reset_outputs("t5_held");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_a('{1, 0, 1, 0, 1, 1});
    send_a(5'b10101);
    wait_ready_a();
    chk("t5_queue_drained", q_a.size(), 0);

    // No-parity DUT with load held high: 1,0,0,0,0 then done, period 7.
    push_b('{1, 0, 0, 0, 0});
    push_b('{1, 0, 0, 0, 0});
    push_b('{1, 0, 0, 0, 0});
    bus_b.i    = 5'b00001;
    bus_b.load = 1'b1;
    n = 0;
    while (q_b.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    bus_b.load = 1'b0;
    chk("t6_frames_completed", q_b.size(), 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t6_period_samples", periods_b, 2);
    chk("t6_idle_after", int'(bus_b.ready), 1);
    chk("end_queue_a_empty", q_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
